// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the five-digit BCD display scanner: digit count,
// digit-index type and the active-low segment patterns ({g,f,e,d,c,b,a}).
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 5;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  typedef logic [2:0] digit_idx_t;

  localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Nibble values 10..15 are not BCD and show a dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Look up the segment pattern for one nibble
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed driver for a five-digit common-anode seven-segment display.
// Each digit is enabled for REFRESH_DIV clocks in turn (0..4); an/seg are
// registered and reflect the index and display register before each edge.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros on
// digits 1..4 (digit 0 always shows).
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BCD_W-1:0]  bcd_in,
  input  logic              load,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [BCD_W-1:0]      r_disp;
  logic [CNT_W-1:0]      r_cnt;
  digit_idx_t            r_idx;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;

  logic                  w_term;
  digit_idx_t            w_idx_next;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [3:0]            w_nibble;
  logic                  w_blank;
  logic [6:0]            w_dec_seg;

  assign w_term     = (r_cnt == CNT_LAST);
  assign w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

  // w_lz[k] is set when digit k is a leading zero that should be blanked
`ifdef LEADING_ZERO_BLANK_EN
  assign w_lz = {r_disp[19:16] == 4'd0,
                 r_disp[19:12] == 8'd0,
                 r_disp[19:8]  == 12'd0,
                 r_disp[19:4]  == 16'd0,
                 1'b0};
`else
  assign w_lz = '0;
`endif

  // Select the nibble and blanking flag of the digit currently being scanned
  always_comb begin
    w_nibble = r_disp[3:0];
    w_blank  = 1'b0;
    case (r_idx)
      3'd1: begin w_nibble = r_disp[7:4];   w_blank = w_lz[1]; end
      3'd2: begin w_nibble = r_disp[11:8];  w_blank = w_lz[2]; end
      3'd3: begin w_nibble = r_disp[15:12]; w_blank = w_lz[3]; end
      3'd4: begin w_nibble = r_disp[19:16]; w_blank = w_lz[4]; end
      default: begin w_nibble = r_disp[3:0]; w_blank = 1'b0; end
    endcase
  end

  bcd_to_7seg u_dec (
    .i_bcd (w_nibble),
    .o_seg (w_dec_seg)
  );

  // Refresh counter and digit index; loads never disturb the scan phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_term) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_cnt <= '0;
      r_idx <= w_idx_next;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Display register: capture on load, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_disp <= '0;
    else if (load) r_disp <= bcd_in;
  end

  // Registered digit enable and segment drive, one cycle behind index/value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~(NUM_DIGITS'(1) << r_idx);
      r_seg <= w_blank ? SEG_BLANK : w_dec_seg;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner with REFRESH_DIV=4.
// Reference model: the scan position is derived from the number of clock
// edges since reset (edges / DIV mod 5); the display value is the last
// loaded word; segments come from a lookup table and the leading-zero rule.
module tb_bcd_display_scanner;

  localparam int DIV  = 4;
  localparam int NDIG = 5;
  localparam int SCAN = DIV * NDIG;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] bcd_in = '0;
  logic        load = 1'b0;
  logic [4:0]  an;
  logic [6:0]  seg;

  int checks   = 0;
  int failures = 0;

  // Model state
  int          edges  = 0;
  logic [19:0] m_disp = '0;
  logic [4:0]  exp_an;
  logic [6:0]  exp_seg;
  logic [6:0]  seg_tab [16];

  bcd_display_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .bcd_in (bcd_in),
    .load   (load),
    .an     (an),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model_seg(input logic [19:0] disp, input int k);
    logic [3:0] nib;
    nib = 4'((disp >> (4 * k)) & 20'hF);
`ifdef LEADING_ZERO_BLANK_EN
    if (k >= 1 && (disp >> (4 * k)) == 20'd0) return 7'b1111111;
`endif
    return seg_tab[nib];
  endfunction

  // Drive one clock: inputs applied now, outputs sampled 1 ns after the edge.
  // Expected outputs come from the model state as it stood before the edge.
  task automatic cycle(input logic ld, input logic [19:0] val);
    int k;
    load   = ld;
    bcd_in = val;
    k       = (edges / DIV) % NDIG;
    exp_an  = ~(5'b00001 << k);
    exp_seg = model_seg(m_disp, k);
    @(posedge clk);
    #1;
    if (ld) m_disp = val;
    edges++;
    load = 1'b0;
  endtask

  task automatic model_reset();
    edges  = 0;
    m_disp = '0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (an !== 5'b11111 || seg !== 7'b1111111) begin
      failures++;
      $display("FAIL reset_hold: an=%b seg=%b expected an=11111 seg=1111111", an, seg);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 20'h0);
    checks++;
    if (an !== 5'b11110 || seg !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_first_edge: an=%b seg=%b expected an=11110 seg=1000000", an, seg);
    end
  endtask

  task automatic run_and_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, $urandom);
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        failures++;
        $display("FAIL %s[%0d]: an=%b seg=%b expected an=%b seg=%b", name, i, an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_scan();
    cycle(1'b1, 20'h12345);
    checks++;
    if (an !== exp_an || seg !== exp_seg) begin
      failures++;
      $display("FAIL scan_load: an=%b seg=%b expected an=%b seg=%b", an, seg, exp_an, exp_seg);
    end
    run_and_check("scan_12345", 2 * SCAN);
  endtask

  task automatic test_zero_blank();
    cycle(1'b1, 20'h00042);
    run_and_check("zero_blank_00042", SCAN + 2);
  endtask

  task automatic test_invalid_digit();
    cycle(1'b1, 20'h0000A);
    run_and_check("invalid_0000A", SCAN + 2);
  endtask

  task automatic test_load_on_terminal();
    int guard;
    guard = 0;
    // Advance until the next edge is the terminal edge of digit 2
    while ((edges % SCAN) != (2 * DIV + DIV - 1) && guard < SCAN + 1) begin
      cycle(1'b0, 20'h0);
      guard++;
    end
    checks++;
    if (guard > SCAN) begin
      failures++;
      $display("FAIL terminal_align: guard=%0d expected <= %0d", guard, SCAN);
    end
    cycle(1'b1, 20'h99999);
    cycle(1'b0, 20'h0);
    checks++;
    if (an !== 5'b10111 || seg !== 7'b0010000) begin
      failures++;
      $display("FAIL terminal_load: an=%b seg=%b expected an=10111 seg=0010000", an, seg);
    end
    // Digit 3 must hold for the full period, then move to digit 4
    for (int i = 1; i < DIV; i++) begin
      cycle(1'b0, 20'h0);
      checks++;
      if (an !== 5'b10111 || seg !== 7'b0010000) begin
        failures++;
        $display("FAIL terminal_phase[%0d]: an=%b seg=%b expected an=10111 seg=0010000", i, an, seg);
      end
    end
    cycle(1'b0, 20'h0);
    checks++;
    if (an !== 5'b01111 || seg !== 7'b0010000) begin
      failures++;
      $display("FAIL terminal_next_digit: an=%b seg=%b expected an=01111 seg=0010000", an, seg);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 20'h11111);
    cycle(1'b1, 20'h22222);
    cycle(1'b1, 20'h67890);
    run_and_check("back_to_back", SCAN);
  endtask

  task automatic test_random();
    logic [19:0] v;
    for (int i = 0; i < 300; i++) begin
      v = '0;
      for (int d = 0; d < NDIG; d++)
        if ($urandom_range(1, 0) == 1) v[4*d +: 4] = 4'($urandom_range(15, 0));
      cycle(($urandom_range(3, 0) == 0), v);
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        failures++;
        $display("FAIL random[%0d]: an=%b seg=%b expected an=%b seg=%b", i, an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 20'h54321);
    cycle(1'b0, 20'h0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (an !== 5'b11111 || seg !== 7'b1111111) begin
      failures++;
      $display("FAIL async_reset_immediate: an=%b seg=%b expected an=11111 seg=1111111", an, seg);
    end
    @(posedge clk);
    #1;
    checks++;
    if (an !== 5'b11111 || seg !== 7'b1111111) begin
      failures++;
      $display("FAIL async_reset_hold: an=%b seg=%b expected an=11111 seg=1111111", an, seg);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 20'h0);
    checks++;
    if (an !== 5'b11110 || seg !== 7'b1000000) begin
      failures++;
      $display("FAIL async_reset_restart: an=%b seg=%b expected an=11110 seg=1000000", an, seg);
    end
    run_and_check("after_reset", SCAN);
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;

    test_reset();
    test_scan();
    test_zero_blank();
    test_invalid_digit();
    test_load_on_terminal();
    test_back_to_back();
    test_random();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
